// File: rtl/can_bit_destuffer.sv
// CAN bit destuffer: samples rx once per bit on the rising edge of the
// recovered baud clock, tracks bus idle / start-of-frame, removes stuff bits
// and flags stuff and sync errors. Strobes appear one clk after baud rises.
//
// Ports:
//   i_clk, i_rst            system clock, synchronous active-high reset
//   i_rx, i_baud, i_lock    synchronised rx line (1 = recessive), baud clock, lock flag
//   i_stuff_en              1 = destuff (SOF..CRC), 0 = pass every bit
//   o_bit_valid, o_bit_data 1-cycle strobe with the destuffed bit value
//   o_sof                   1-cycle strobe on the SOF bit
//   o_stuff_err, o_sync_err 1-cycle error strobes
//   o_bus_idle              level: idle run seen and no frame active
module can_bit_destuffer #(
  parameter int STUFF_LEN = 5,
  parameter int IDLE_BITS = 11,
  parameter int CNT_WIDTH = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rx,
  input  logic i_baud,
  input  logic i_lock,
  input  logic i_stuff_en,
  output logic o_bit_valid,
  output logic o_bit_data,
  output logic o_sof,
  output logic o_stuff_err,
  output logic o_sync_err,
  output logic o_bus_idle
);

  typedef enum logic [1:0] {HUNT, IDLE, FRAME} state_t;

  localparam logic [CNT_WIDTH-1:0] STUFF_MAX = CNT_WIDTH'(STUFF_LEN);
  localparam logic [CNT_WIDTH-1:0] IDLE_MAX  = CNT_WIDTH'(IDLE_BITS);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  state_t               r_state, w_state_nxt;
  logic                 r_baud_q;
  logic [CNT_WIDTH-1:0] r_run, w_run_nxt;
  logic [CNT_WIDTH-1:0] r_rec_run, w_rec_nxt;
  logic                 r_last, w_last_nxt;

  logic                 w_samp;
  logic [CNT_WIDTH-1:0] w_rec_inc, w_run_inc;
  logic                 w_bv, w_bd, w_sof, w_serr, w_yerr, w_idle;

  // baud_q resets high so a baud already high at reset release is no sample.
  assign w_samp    = i_baud & ~r_baud_q;
  assign w_rec_inc = (r_rec_run == IDLE_MAX)  ? IDLE_MAX  : r_rec_run + CNT_ONE;
  assign w_run_inc = (r_run     == STUFF_MAX) ? STUFF_MAX : r_run + CNT_ONE;

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_rec_nxt   = r_rec_run;
    w_last_nxt  = r_last;
    w_bv        = 1'b0;
    w_bd        = o_bit_data;
    w_sof       = 1'b0;
    w_serr      = 1'b0;
    w_yerr      = 1'b0;
    w_idle      = o_bus_idle;

    if (w_samp) begin
      // Recessive run counts every raw sample, stuff bits included.
      w_rec_nxt = i_rx ? w_rec_inc : '0;
      case (r_state)
        HUNT: begin
          if (!i_lock) begin
            w_rec_nxt = '0;
          end else if (w_rec_nxt == IDLE_MAX) begin
            w_idle      = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        IDLE: begin
          if (!i_rx) begin
            w_idle = 1'b0;
            if (i_lock) begin
              w_bv        = 1'b1;
              w_bd        = 1'b0;
              w_sof       = 1'b1;
              w_last_nxt  = 1'b0;
              w_run_nxt   = CNT_ONE;
              w_state_nxt = FRAME;
            end else begin
              w_yerr      = 1'b1;
              w_state_nxt = HUNT;
            end
          end
        end
        FRAME: begin
          if (!i_lock) begin
            w_yerr      = 1'b1;
            w_state_nxt = HUNT;
          end else if (i_stuff_en && (r_run == STUFF_MAX)) begin
            // This sample is a stuff bit: it must differ from the run.
            if (i_rx == r_last) begin
              w_serr      = 1'b1;
              w_state_nxt = HUNT;
            end else begin
              w_last_nxt = i_rx;
              w_run_nxt  = CNT_ONE;
            end
          end else begin
            w_bv = 1'b1;
            w_bd = i_rx;
            if (i_rx == r_last) begin
              w_run_nxt = w_run_inc;
            end else begin
              w_run_nxt  = CNT_ONE;
              w_last_nxt = i_rx;
            end
            // Unstuffed tail (EOF + intermission) ends the frame.
            if (!i_stuff_en && (w_rec_nxt == IDLE_MAX)) begin
              w_idle      = 1'b1;
              w_state_nxt = IDLE;
            end
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= HUNT;
      r_baud_q    <= 1'b1;
      r_run       <= '0;
      r_rec_run   <= '0;
      r_last      <= 1'b1;
      o_bit_valid <= 1'b0;
      o_bit_data  <= 1'b1;
      o_sof       <= 1'b0;
      o_stuff_err <= 1'b0;
      o_sync_err  <= 1'b0;
      o_bus_idle  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_baud_q    <= i_baud;
      r_run       <= w_run_nxt;
      r_rec_run   <= w_rec_nxt;
      r_last      <= w_last_nxt;
      o_bit_valid <= w_bv;
      o_bit_data  <= w_bd;
      o_sof       <= w_sof;
      o_stuff_err <= w_serr;
      o_sync_err  <= w_yerr;
      o_bus_idle  <= w_idle;
    end
  end

endmodule

// File: tb/tb_can_bit_destuffer.sv
// Testbench for can_bit_destuffer: directed scenarios followed by randomized
// traffic, every sample compared with a queue-based reference model.
module tb_can_bit_destuffer;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_rx = 1'b1, i_baud = 1'b0, i_lock = 1'b1, i_stuff_en = 1'b1;
  logic o_bit_valid, o_bit_data, o_sof, o_stuff_err, o_sync_err, o_bus_idle;

  can_bit_destuffer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rx(i_rx), .i_baud(i_baud),
    .i_lock(i_lock), .i_stuff_en(i_stuff_en),
    .o_bit_valid(o_bit_valid), .o_bit_data(o_bit_data), .o_sof(o_sof),
    .o_stuff_err(o_stuff_err), .o_sync_err(o_sync_err), .o_bus_idle(o_bus_idle)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_bv     = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: bus mode plus raw-sample histories.
  // mode 0 = hunting for idle, 1 = bus idle, 2 = inside a frame.
  int mode;
  bit q_all[$];  // raw samples since last lock loss while hunting
  bit q_frm[$];  // raw samples since SOF (stuff bits included)
  bit e_bv, e_bd, e_sof, e_serr, e_yerr, e_idle;

  function automatic int trail_ones();
    int n = 0;
    for (int i = q_all.size() - 1; i >= 0; i--) begin
      if (q_all[i]) n++;
      else break;
    end
    return (n > 11) ? 11 : n;
  endfunction

  function automatic int trail_same();
    int n = 0;
    for (int i = q_frm.size() - 1; i >= 0; i--) begin
      if (q_frm[i] == q_frm[q_frm.size() - 1]) n++;
      else break;
    end
    return (n > 5) ? 5 : n;
  endfunction

  function automatic void model_reset();
    mode = 0;
    q_all.delete();
    q_frm.delete();
    e_bv = 0; e_bd = 1; e_sof = 0; e_serr = 0; e_yerr = 0; e_idle = 0;
  endfunction

  function automatic void model_step(input bit rx, input bit lk, input bit se);
    int rec, run;
    bit last;
    e_bv = 0; e_sof = 0; e_serr = 0; e_yerr = 0;
    if (mode == 0 && !lk) begin
      q_all.delete();
      return;
    end
    q_all.push_back(rx);
    if (q_all.size() > 16) void'(q_all.pop_front());
    rec = trail_ones();
    case (mode)
      0: if (rec == 11) begin e_idle = 1; mode = 1; end
      1: if (!rx) begin
           e_idle = 0;
           if (lk) begin
             e_bv = 1; e_bd = 0; e_sof = 1; mode = 2;
             q_frm.delete();
             q_frm.push_back(1'b0);
           end else begin
             e_yerr = 1; mode = 0;
           end
         end
      default: begin
        if (!lk) begin
          e_yerr = 1; mode = 0;
        end else begin
          run  = trail_same();
          last = q_frm[q_frm.size() - 1];
          if (se && run == 5) begin
            if (rx == last) begin e_serr = 1; mode = 0; end
            else q_frm.push_back(rx);
          end else begin
            e_bv = 1; e_bd = rx;
            q_frm.push_back(rx);
            if (!se && rec == 11) begin e_idle = 1; mode = 1; end
          end
          if (q_frm.size() > 16) void'(q_frm.pop_front());
        end
      end
    endcase
  endfunction

  function automatic logic [31:0] dut_vec();
    return {26'd0, o_bit_valid, o_bit_data, o_sof, o_stuff_err, o_sync_err, o_bus_idle};
  endfunction

  function automatic logic [31:0] exp_vec(input bit strobes);
    return {26'd0, e_bv & strobes, e_bd, e_sof & strobes, e_serr & strobes,
            e_yerr & strobes, e_idle};
  endfunction

  // One bit period: baud high two clks, low two clks.
  task automatic do_sample(input bit rx, input bit lk, input bit se);
    @(negedge i_clk);
    i_rx = rx; i_lock = lk; i_stuff_en = se; i_baud = 1'b1;
    model_step(rx, lk, se);
    @(negedge i_clk);
    check_eq("sample", dut_vec(), exp_vec(1'b1));
    if (o_bit_valid) n_bv++;
    @(negedge i_clk);
    check_eq("strobe_1clk", dut_vec(), exp_vec(1'b0));
    i_baud = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic send_ones(input int n, input bit se);
    for (int i = 0; i < n; i++) do_sample(1'b1, 1'b1, se);
  endtask

  initial begin
    bit se_r;
    model_reset();
    repeat (3) @(negedge i_clk);
    check_eq("reset_vals", dut_vec(), 32'h10);
    i_rst = 1'b0;

    // Idle detection: no bit_valid, bus_idle on the 11th recessive sample.
    n_bv = 0;
    send_ones(10, 1'b1);
    check_eq("idle_not_yet", {31'd0, o_bus_idle}, 32'd0);
    send_ones(1, 1'b1);
    check_eq("idle_after_11", {31'd0, o_bus_idle}, 32'd1);
    check_eq("hunt_no_bits", n_bv, 0);

    // SOF plus one stuff bit removed: 8 samples, 7 strobes.
    n_bv = 0;
    begin
      logic [7:0] pat;
      pat = 8'b0000_0110;
      for (int i = 7; i >= 0; i--) do_sample(pat[i], 1'b1, 1'b1);
    end
    check_eq("destuff_count", n_bv, 7);

    // Five recessive bits then a sixth: stuff error.
    n_bv = 0;
    send_ones(6, 1'b1);
    check_eq("stuff_err_bits", n_bv, 5);
    check_eq("stuff_err_mode", mode, 0);

    // Recover, then unstuffed 11 recessive bits close the frame.
    send_ones(11, 1'b1);
    do_sample(1'b0, 1'b1, 1'b0);
    n_bv = 0;
    send_ones(11, 1'b0);
    check_eq("eof_bits", n_bv, 11);
    check_eq("eof_idle", {31'd0, o_bus_idle}, 32'd1);

    // Lock lost mid-frame.
    do_sample(1'b0, 1'b1, 1'b1);
    do_sample(1'b1, 1'b1, 1'b1);
    do_sample(1'b0, 1'b0, 1'b1);
    check_eq("sync_mode", mode, 0);

    // Reset mid-frame with baud held high across the release.
    send_ones(11, 1'b1);
    do_sample(1'b0, 1'b1, 1'b1);
    do_sample(1'b1, 1'b1, 1'b1);
    @(negedge i_clk);
    i_rst = 1'b1; i_baud = 1'b1; i_rx = 1'b1;
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    check_eq("rst_release", dut_vec(), exp_vec(1'b1));
    @(negedge i_clk);
    check_eq("rst_no_samp", dut_vec(), exp_vec(1'b1));
    i_baud = 1'b0;
    @(negedge i_clk);
    send_ones(10, 1'b1);
    check_eq("rst_idle_wait", {31'd0, o_bus_idle}, 32'd0);
    send_ones(1, 1'b1);
    check_eq("rst_idle", {31'd0, o_bus_idle}, 32'd1);

    // Randomized traffic with occasional lock loss and stuff_en phases.
    se_r = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (i % 40 == 0) se_r = ($urandom_range(0, 3) != 0);
      do_sample($urandom_range(0, 3) != 0, $urandom_range(0, 31) != 0, se_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
